// File: rtl/muldiv_seq_unit.sv
// Iterative signed MUL/DIV (shift-add / restoring); WIDTH+2 edges start-to-done-end, start ignored while busy.
// Optional MULDIV_RADIX4_EN: radix-4 Booth MUL in WIDTH/2+2 edges, DIV unchanged.
module muldiv_seq_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(WIDTH - 1);

  state_t               state, state_nxt;
  logic                 op_q, sign_a, sign_b;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH-1:0]     abs_a, abs_b, signed_a;
  logic [2*WIDTH-1:0]   acc, mul_nxt, div_nxt, mul_res;
  logic [CNT_W-1:0]     cnt, last_cnt;
  logic                 calc_last;

  // Restoring-division step: acc = {remainder, dividend bits still to shift in}
  logic [WIDTH:0]       div_shift;
  logic [WIDTH-1:0]     rem_sub;
  logic                 div_ge;

  assign abs_a    = a[WIDTH-1] ? -a : a;
  assign abs_b    = b[WIDTH-1] ? -b : b;
  assign signed_a = sign_a ? -mag_a : mag_a;

`ifdef MULDIV_RADIX4_EN
  localparam logic [CNT_W-1:0] LAST_HALF = CNT_W'(WIDTH / 2 - 1);
  logic [WIDTH:0]       mb;
  logic [WIDTH+1:0]     a_ext, pp;
  logic [2*WIDTH-1:0]   pp_ext;

  // Booth works on the signed operands directly, so the product needs no sign fix
  always_comb begin
    a_ext = {{2{signed_a[WIDTH-1]}}, signed_a};
    pp    = '0;
    case (mb[2:0])
      3'b001, 3'b010: pp = a_ext;
      3'b011:         pp = a_ext << 1;
      3'b100:         pp = -(a_ext << 1);
      3'b101, 3'b110: pp = -a_ext;
      default:        pp = '0;
    endcase
    pp_ext  = {{(WIDTH-2){pp[WIDTH+1]}}, pp};
    mul_nxt = acc + (pp_ext << {cnt, 1'b0});
    mul_res = acc;
  end
  assign last_cnt = op_q ? LAST_FULL : LAST_HALF;
`else
  logic [WIDTH:0]       add_sum;

  always_comb begin
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
    mul_nxt = {add_sum, acc[WIDTH-1:1]};
    mul_res = (sign_a ^ sign_b) ? -acc : acc;
  end
  assign last_cnt = LAST_FULL;
`endif

  always_comb begin
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_ge    = div_shift >= {1'b0, mag_b};
    rem_sub   = div_shift[WIDTH-1:0] - mag_b;
    div_nxt   = div_ge ? {rem_sub, acc[WIDTH-2:0], 1'b1}
                       : {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  assign calc_last = (cnt == last_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = CALC;
      end
      CALC: if (calc_last) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= 1'b0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      mag_a       <= '0;
      mag_b       <= '0;
      acc         <= '0;
      cnt         <= '0;
      result_hi   <= '0;
      result_lo   <= '0;
      div_by_zero <= 1'b0;
`ifdef MULDIV_RADIX4_EN
      mb          <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q        <= op;
          sign_a      <= a[WIDTH-1];
          sign_b      <= b[WIDTH-1];
          mag_a       <= abs_a;
          mag_b       <= abs_b;
          cnt         <= '0;
          div_by_zero <= 1'b0;
`ifdef MULDIV_RADIX4_EN
          mb          <= {b, 1'b0};
          acc         <= op ? {{WIDTH{1'b0}}, abs_a} : '0;
`else
          acc         <= {{WIDTH{1'b0}}, (op ? abs_a : abs_b)};
`endif
        end
        CALC: begin
          acc <= op_q ? div_nxt : mul_nxt;
          cnt <= cnt + CNT_W'(1);
`ifdef MULDIV_RADIX4_EN
          mb  <= mb >> 2;
`endif
        end
        FIX: begin
          if (!op_q) begin
            {result_hi, result_lo} <= mul_res;
          end else if (mag_b == '0) begin
            result_hi   <= signed_a;
            result_lo   <= '1;
            div_by_zero <= 1'b1;
          end else begin
            result_lo <= (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            result_hi <= sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Randomised and directed bench for muldiv_seq_unit against a plain-arithmetic reference model.
module tb_muldiv_seq_unit;
  localparam int W = 32;
`ifdef MULDIV_RADIX4_EN
  localparam int MUL_LAT = W / 2 + 2;
`else
  localparam int MUL_LAT = W + 2;
`endif
  localparam int DIV_LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst_n, start, op;
  logic [W-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] result_hi, result_lo;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  muldiv_seq_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result_hi(result_hi), .result_lo(result_lo),
    .div_by_zero(div_by_zero)
  );

  function automatic void model(input logic o, input logic [W-1:0] x, y,
                                output logic [W-1:0] hi, lo, output logic dz);
    longint sx, sy, p, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    dz = 1'b0;
    if (!o) begin
      p  = sx * sy;
      hi = p[63:32];
      lo = p[31:0];
    end else if (y == 0) begin
      hi = x;
      lo = '1;
      dz = 1'b1;
    end else begin
      q  = sx / sy;
      r  = sx % sy;
      hi = r[31:0];
      lo = q[31:0];
    end
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Drives one operation; pulses start during CALC at pulse_at and again in the done cycle.
  task automatic run_op(input logic o, input logic [W-1:0] x, y, input int pulse_at,
                        output int lat, output logic [W-1:0] hi, lo, output logic dz,
                        output logic busy_e0, output logic idle_after,
                        output int extra_dones, output logic held);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    busy_e0 = busy;
    start = 1'b0; a = $urandom; b = $urandom; op = $urandom;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (done === 1'b1) break;
      start = (lat == pulse_at);
      if (start) begin a = $urandom; b = $urandom; op = $urandom; end
    end
    lat = lat + 1;
    hi = result_hi; lo = result_lo; dz = div_by_zero;
    start = 1'b1; a = $urandom; b = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    idle_after = (busy === 1'b0) && (done === 1'b0);
    extra_dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) extra_dones++;
    end
    held = (result_hi === hi) && (result_lo === lo);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    #1;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || result_hi !== '0 || result_lo !== '0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b dz=%b hi=%h lo=%h, required all 0",
               busy, done, div_by_zero, result_hi, result_lo);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic         t_op [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] t_a  [6] = '{32'd22, 32'd26, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000};
    logic [W-1:0] t_b  [6] = '{32'd24, 32'd24, 32'd2, 32'd3, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [W-1:0] t_hi [6] = '{32'h0, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h4000_0000, 32'h0};
    logic [W-1:0] t_lo [6] = '{32'h210, 32'h1, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 32'h0, 32'h8000_0000};
    int lat, extra; logic [W-1:0] hi, lo; logic dz, be0, idle, held;
    for (int i = 0; i < 6; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], -1, lat, hi, lo, dz, be0, idle, extra, held);
      checks++;
      if (hi !== t_hi[i] || lo !== t_lo[i] || dz !== 1'b0) begin
        errors++;
        $display("FAIL directed[%0d]: hi=%h lo=%h dz=%b, required hi=%h lo=%h dz=0",
                 i, hi, lo, dz, t_hi[i], t_lo[i]);
      end
      checks++;
      if (lat != (t_op[i] ? DIV_LAT : MUL_LAT) || be0 !== 1'b1 || !idle) begin
        errors++;
        $display("FAIL directed_timing[%0d]: latency=%0d busy_e0=%b idle_after=%b, required %0d/1/1",
                 i, lat, be0, idle, t_op[i] ? DIV_LAT : MUL_LAT);
      end
    end
  endtask

  task automatic test_div_by_zero();
    int lat, extra; logic [W-1:0] hi, lo; logic dz, be0, idle, held;
    run_op(1'b1, 32'h1234, 32'h0, -1, lat, hi, lo, dz, be0, idle, extra, held);
    checks++;
    if (hi !== 32'h1234 || lo !== 32'hFFFF_FFFF || dz !== 1'b1 || lat != DIV_LAT) begin
      errors++;
      $display("FAIL div_by_zero: hi=%h lo=%h dz=%b lat=%0d, required 00001234/ffffffff/1/%0d",
               hi, lo, dz, lat, DIV_LAT);
    end
    checks++;
    if (div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL dz_sticky: dz=%b in idle, required 1", div_by_zero);
    end
    run_op(1'b0, 32'd5, 32'd7, -1, lat, hi, lo, dz, be0, idle, extra, held);
    checks++;
    if (dz !== 1'b0 || lo !== 32'd35) begin
      errors++;
      $display("FAIL dz_clear: dz=%b lo=%h, required 0/00000023", dz, lo);
    end
  endtask

  task automatic test_ignore_start();
    int lat, extra; logic [W-1:0] hi, lo; logic dz, be0, idle, held;
    run_op(1'b0, 32'd1000, 32'hFFFF_FFFE, 5, lat, hi, lo, dz, be0, idle, extra, held);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_F830 || lat != MUL_LAT) begin
      errors++;
      $display("FAIL ignore_start_result: hi=%h lo=%h lat=%0d, required ffffffff/fffff830/%0d",
               hi, lo, lat, MUL_LAT);
    end
    checks++;
    if (!idle || extra != 0 || !held) begin
      errors++;
      $display("FAIL ignore_start_pulses: idle_after=%b extra_activity=%0d held=%b, required 1/0/1",
               idle, extra, held);
    end
  endtask

  task automatic test_reset_abort();
    int lat, extra; logic [W-1:0] hi, lo; logic dz, be0, idle, held;
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = 32'h7654_3210; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || result_hi !== '0 || result_lo !== '0) begin
      errors++;
      $display("FAIL reset_abort: busy=%b done=%b dz=%b hi=%h lo=%h, required all 0",
               busy, done, div_by_zero, result_hi, result_lo);
    end
    @(negedge clk); rst_n = 1'b1;
    run_op(1'b0, 32'd22, 32'd24, -1, lat, hi, lo, dz, be0, idle, extra, held);
    checks++;
    if (hi !== 32'h0 || lo !== 32'h210 || lat != MUL_LAT) begin
      errors++;
      $display("FAIL after_abort: hi=%h lo=%h lat=%0d, required 00000000/00000210/%0d",
               hi, lo, lat, MUL_LAT);
    end
  endtask

  task automatic test_random();
    int lat, extra; logic [W-1:0] hi, lo, ehi, elo, x, y; logic dz, edz, be0, idle, held, o;
    for (int n = 0; n < 40; n++) begin
      o = $urandom; x = pick(); y = pick();
      model(o, x, y, ehi, elo, edz);
      run_op(o, x, y, -1, lat, hi, lo, dz, be0, idle, extra, held);
      checks++;
      if (hi !== ehi || lo !== elo || dz !== edz) begin
        errors++;
        $display("FAIL random[%0d] op=%b a=%h b=%h: hi=%h lo=%h dz=%b, required hi=%h lo=%h dz=%b",
                 n, o, x, y, hi, lo, dz, ehi, elo, edz);
      end
      checks++;
      if (lat != (o ? DIV_LAT : MUL_LAT) || !idle || extra != 0 || !held) begin
        errors++;
        $display("FAIL random_timing[%0d]: lat=%0d idle=%b extra=%0d held=%b, required %0d/1/0/1",
                 n, lat, idle, extra, held, o ? DIV_LAT : MUL_LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_by_zero();
    test_ignore_start();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
